// File: rtl/radiant_trig_coinc.sv
// radiant_trig_coinc: parametrised multi-trigger majority coincidence with holdoff, prescale and counters
module radiant_trig_coinc #(
    parameter int NUM_CH         = 24,
    parameter int NUM_TRIG       = 4,
    parameter int WINDOW_WIDTH   = 8,
    parameter int THRESH_WIDTH   = 5,
    parameter int HOLDOFF_WIDTH  = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_CH-1:0]                  trig_i,
    input  logic [NUM_CH-1:0]                  chan_en_i,
    input  logic [NUM_TRIG*NUM_CH-1:0]         trig_maskb_i,
    input  logic [NUM_TRIG-1:0]                trig_en_i,
    input  logic [NUM_TRIG*WINDOW_WIDTH-1:0]   trig_window_i,
    input  logic [NUM_TRIG*THRESH_WIDTH-1:0]   trig_thresh_i,
    input  logic [NUM_TRIG*HOLDOFF_WIDTH-1:0]  trig_holdoff_i,
    input  logic [NUM_TRIG*PRESCALE_WIDTH-1:0] trig_prescale_i,
    input  logic                               count_clear_i,
    output logic [NUM_TRIG-1:0]                trig_o,
    output logic [NUM_TRIG-1:0]                trig_busy_o,
    output logic [NUM_TRIG*32-1:0]             trig_count_o
);
    localparam int POP_W = $clog2(NUM_CH + 1);
    typedef enum logic {IDLE, HOLDOFF} state_t;
    genvar t;
    for (t = 0; t < NUM_TRIG; t++) begin : g_trig
        logic [NUM_CH-1:0]         hit;
        logic [WINDOW_WIDTH-1:0]   win_q [NUM_CH];
        logic [WINDOW_WIDTH-1:0]   win_cfg;
        logic [THRESH_WIDTH-1:0]   thr_cfg;
        logic [HOLDOFF_WIDTH-1:0]  hold_cfg;
        logic [PRESCALE_WIDTH-1:0] pre_cfg;
        logic [POP_W-1:0]          pop_d;
        logic [POP_W-1:0]          pop_q;
        logic                      cond_q;
        logic                      cond_dq;
        logic                      fire;
        logic                      emit;
        logic                      busy;
        logic                      clr;
        state_t                    state_q;
        state_t                    state_d;
        logic [HOLDOFF_WIDTH-1:0]  hold_q;
        logic [PRESCALE_WIDTH-1:0] pc_q;
        logic [31:0]               count_q;
        assign win_cfg  = trig_window_i[t*WINDOW_WIDTH +: WINDOW_WIDTH];
        assign thr_cfg  = trig_thresh_i[t*THRESH_WIDTH +: THRESH_WIDTH];
        assign hold_cfg = trig_holdoff_i[t*HOLDOFF_WIDTH +: HOLDOFF_WIDTH];
        assign pre_cfg  = trig_prescale_i[t*PRESCALE_WIDTH +: PRESCALE_WIDTH];
        assign clr      = rst_i | ~trig_en_i[t];
        assign hit      = trig_i & chan_en_i & trig_maskb_i[t*NUM_CH +: NUM_CH];
        assign fire     = cond_q & ~cond_dq;
        // per-channel coincidence windows: a hit reloads, otherwise count down to zero
        always_ff @(posedge clk_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr) win_q[c] <= '0;
                else if (hit[c]) win_q[c] <= win_cfg;
                else if (win_q[c] != '0) win_q[c] <= win_q[c] - 1'b1;
            end
        end
        // number of channels currently inside their window
        always_comb begin
            pop_d = '0;
            for (int c = 0; c < NUM_CH; c++) pop_d = pop_d + POP_W'(win_q[c] != '0);
        end
        // registered popcount, threshold compare and its delayed copy for edge detection
        always_ff @(posedge clk_i) begin
            if (clr) begin
                pop_q   <= '0;
                cond_q  <= 1'b0;
                cond_dq <= 1'b0;
            end else begin
                pop_q   <= pop_d;
                cond_q  <= (32'(pop_q) >= 32'(thr_cfg)) && (thr_cfg != '0);
                cond_dq <= cond_q;
            end
        end
        // holdoff state register
        always_ff @(posedge clk_i) state_q <= clr ? IDLE : state_d;
        // a fire in IDLE starts holdoff; holdoff ends once its counter has reached zero
        always_comb state_d = (state_q == IDLE) ? (fire ? HOLDOFF : IDLE) : (hold_q == '0 ? IDLE : HOLDOFF);
        // only a prescale-selected fire taken in IDLE leaves the block
        always_comb begin
            busy = state_q == HOLDOFF;
            emit = ~clr & (state_q == IDLE) & fire & (pc_q == pre_cfg);
        end
        // holdoff and prescale counters, both loaded from the config seen at the fire
        always_ff @(posedge clk_i) begin
            if (clr) begin
                hold_q <= '0;
                pc_q   <= '0;
            end else if (state_q == IDLE && fire) begin
                hold_q <= hold_cfg;
                pc_q   <= (pc_q == pre_cfg) ? '0 : pc_q + 1'b1;
            end else if (state_q == HOLDOFF && hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end
        end
        // saturating emitted-trigger counter; survives trigger disable, clear beats increment
        always_ff @(posedge clk_i) begin
            if (rst_i || count_clear_i) count_q <= '0;
            else if (emit && count_q != '1) count_q <= count_q + 1'b1;
        end
        assign trig_o[t]                = emit;
        assign trig_busy_o[t]           = busy;
        assign trig_count_o[t*32 +: 32] = count_q;
    end
endmodule

// File: tb/tb_radiant_trig_coinc.sv
// tb_radiant_trig_coinc: directed table and sequence checks of the coincidence trigger
module tb_radiant_trig_coinc;
    localparam int NC = 24;
    localparam int NT = 4;
    localparam int WW = 8;
    localparam int TW = 5;
    localparam int HW = 16;
    localparam int PW = 8;
    localparam logic [NC-1:0] ALL = '1;

    typedef struct {
        logic [NC-1:0] hits;
        logic [NT-1:0] et;
        logic [NT-1:0] eb;
    } vec_t;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [NC-1:0]      trig_i;
    logic [NC-1:0]      chan_en_i;
    logic [NT*NC-1:0]   trig_maskb_i;
    logic [NT-1:0]      trig_en_i;
    logic [NT*WW-1:0]   trig_window_i;
    logic [NT*TW-1:0]   trig_thresh_i;
    logic [NT*HW-1:0]   trig_holdoff_i;
    logic [NT*PW-1:0]   trig_prescale_i;
    logic               count_clear_i;
    logic [NT-1:0]      trig_o;
    logic [NT-1:0]      trig_busy_o;
    logic [NT*32-1:0]   trig_count_o;

    int n_pass = 0;
    int n_total = 0;
    vec_t tab [80];

    always #5 clk_i = ~clk_i;

    radiant_trig_coinc dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .trig_i          (trig_i),
        .chan_en_i       (chan_en_i),
        .trig_maskb_i    (trig_maskb_i),
        .trig_en_i       (trig_en_i),
        .trig_window_i   (trig_window_i),
        .trig_thresh_i   (trig_thresh_i),
        .trig_holdoff_i  (trig_holdoff_i),
        .trig_prescale_i (trig_prescale_i),
        .count_clear_i   (count_clear_i),
        .trig_o          (trig_o),
        .trig_busy_o     (trig_busy_o),
        .trig_count_o    (trig_count_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic step(input logic [NC-1:0] h, input logic [NT-1:0] et, input logic [NT-1:0] eb, input string nm);
        trig_i = h;
        @(negedge clk_i);
        chk({nm, " trig_o"}, 32'(trig_o), 32'(et));
        chk({nm, " busy"}, 32'(trig_busy_o), 32'(eb));
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg(input int t, input logic [NC-1:0] m, input logic [WW-1:0] w,
                       input logic [TW-1:0] th, input logic [HW-1:0] h, input logic [PW-1:0] p);
        trig_maskb_i[t*NC +: NC]    = m;
        trig_window_i[t*WW +: WW]   = w;
        trig_thresh_i[t*TW +: TW]   = th;
        trig_holdoff_i[t*HW +: HW]  = h;
        trig_prescale_i[t*PW +: PW] = p;
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        trig_i = '0;
        count_clear_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    function automatic logic [31:0] cnt(input int t);
        return trig_count_o[t*32 +: 32];
    endfunction

    initial begin
        rst_i = 1'b1;
        trig_i = '0;
        count_clear_i = 1'b0;
        chan_en_i = 24'hFFFF7F;
        trig_en_i = 4'b0111;
        cfg(0, ALL, 8'd4, 5'd2, 16'd2, 8'd0);
        cfg(1, 24'hFFFFDF, 8'd4, 5'd2, 16'd0, 8'd0);
        cfg(2, ALL, 8'd0, 5'd1, 16'd0, 8'd0);
        cfg(3, ALL, 8'd4, 5'd1, 16'd0, 8'd0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset trig_o", 32'(trig_o), 32'd0);
        chk("reset busy", 32'(trig_busy_o), 32'd0);
        chk("reset count", trig_count_o[31:0] | trig_count_o[63:32] | trig_count_o[95:64] | trig_count_o[127:96], 32'd0);
        rst_i = 1'b0;

        // table: window coincidence, expiry, mask, channel enable, W=0, disabled trigger
        for (int i = 0; i < 80; i++) tab[i] = '{hits: '0, et: '0, eb: '0};
        tab[10].hits = 24'h000001;
        tab[13].hits = 24'h000020;
        tab[16].et   = 4'b0001;
        for (int i = 17; i <= 19; i++) tab[i].eb = 4'b0001;
        tab[30].hits = 24'h000001;
        tab[35].hits = 24'h000020;
        tab[50].hits = 24'h000003;
        tab[53].et   = 4'b0011;
        tab[54].eb   = 4'b0011;
        tab[55].eb   = 4'b0001;
        tab[56].eb   = 4'b0001;
        tab[70].hits = 24'h000081;
        for (int i = 0; i < 80; i++) step(tab[i].hits, tab[i].et, tab[i].eb, $sformatf("table[%0d]", i));
        chk("table count0", cnt(0), 32'd2);
        chk("table count1", cnt(1), 32'd1);
        chk("table count2", cnt(2), 32'd0);
        chk("table count3", cnt(3), 32'd0);

        // long holdoff swallows a second coincidence
        chan_en_i = ALL;
        trig_en_i = 4'b0001;
        cfg(0, ALL, 8'd4, 5'd3, 16'd100, 8'd0);
        do_reset;
        for (int c = 0; c <= 130; c++)
            step((c == 10) ? 24'h7 : (c == 20) ? 24'h38 : 24'h0, 4'(c == 13), 4'(c >= 14 && c <= 114), "holdoff");
        chk("holdoff count", cnt(0), 32'd1);

        // prescale 2: only every third fire emitted, all fires enter holdoff
        cfg(0, ALL, 8'd2, 5'd2, 16'd0, 8'd2);
        do_reset;
        for (int c = 0; c <= 70; c++)
            step((c % 10 == 0 && c >= 10 && c <= 60) ? 24'h3 : 24'h0, 4'(c == 33 || c == 63),
                 4'(c % 10 == 4 && c >= 14 && c <= 64), "prescale");
        chk("prescale count", cnt(0), 32'd2);

        // saturation and clear-over-increment
        cfg(0, ALL, 8'd2, 5'd2, 16'd0, 8'd0);
        do_reset;
        force dut.g_trig[0].count_q = 32'hFFFF_FFFE;
        @(posedge clk_i);
        #1;
        release dut.g_trig[0].count_q;
        for (int c = 0; c < 30; c++) begin
            if (c == 5) chk("sat first", cnt(0), 32'hFFFF_FFFF);
            if (c == 15) chk("sat hold", cnt(0), 32'hFFFF_FFFF);
            if (c == 25) chk("clear wins", cnt(0), 32'd0);
            count_clear_i = (c == 23);
            step((c % 10 == 0) ? 24'h3 : 24'h0, 4'(c % 10 == 3), 4'(c % 10 == 4), "saturate");
        end
        count_clear_i = 1'b0;

        // disable during holdoff clears state and prescaler; reset mid-holdoff clears counts
        cfg(0, ALL, 8'd2, 5'd2, 16'd20, 8'd1);
        do_reset;
        for (int c = 0; c <= 80; c++) begin
            if (c == 65) chk("pre-reset count", cnt(0), 32'd1);
            if (c == 68) chk("post-reset count", cnt(0), 32'd0);
            trig_en_i = (c == 20 || c == 21) ? 4'b0000 : 4'b0001;
            rst_i = (c == 66);
            step((c == 10 || c == 30 || c == 60) ? 24'h3 : 24'h0, 4'(c == 63),
                 4'((c >= 14 && c <= 20) || (c >= 34 && c <= 54) || (c >= 64 && c <= 66)), "enable");
        end
        rst_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
